// File: rtl/ps2_mouse_responder.sv
// ps2_mouse_responder: PS/2 mouse device-side command responder (BAT, ID, ACK, streaming packets).
// Define PS2_RESP_ERR_EN to answer unsupported host commands with 0xFE instead of 0xFA.
module ps2_mouse_responder #(
   parameter int BAT_DELAY = 16
) (
   input  logic        clk_sys,
   input  logic        rst_n,
   input  logic        rx_vld,
   input  logic [7:0]  rx_data,
   output logic        tx_en,
   output logic [7:0]  tx_data,
   input  logic        tx_done,
   input  logic        pkt_req,
   input  logic [23:0] pkt_data,
   output logic        pkt_ack,
   output logic        stream_en,
   output logic [2:0]  current_state
);
`ifdef PS2_RESP_ERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif
   typedef enum logic [2:0] {
      BAT_WAIT  = 3'd0,
      SEND_BAT  = 3'd1,
      SEND_ID   = 3'd2,
      IDLE      = 3'd3,
      SEND_ACK  = 3'd4,
      SEND_RESP = 3'd5,
      SEND_PKT  = 3'd6
   } state_t;
   state_t      state;
   logic [31:0] cnt;
   logic        pend_vld;
   logic [7:0]  pend_cmd;
   logic [7:0]  cur_cmd;
   logic [15:0] pkt_hi;
   logic [1:0]  idx;
   assign current_state = state;
   function automatic logic [7:0] ack_byte(input logic [7:0] c);
      return (ERR_EN && !(c inside {8'hFF, 8'hF4, 8'hF5, 8'hF2})) ? 8'hFE : 8'hFA;
   endfunction
   task automatic start_ack(input logic [7:0] c);
      state   <= SEND_ACK;
      tx_en   <= 1'b1;
      tx_data <= ack_byte(c);
      cur_cmd <= c;
   endtask
   always_ff @(posedge clk_sys) begin
      if (!rst_n) begin
         state     <= BAT_WAIT;
         cnt       <= '0;
         tx_en     <= 1'b0;
         tx_data   <= 8'h00;
         pkt_ack   <= 1'b0;
         stream_en <= 1'b0;
         pend_vld  <= 1'b0;
         pend_cmd  <= 8'h00;
         cur_cmd   <= 8'h00;
         pkt_hi    <= '0;
         idx       <= '0;
      end else begin
         tx_en   <= 1'b0;
         pkt_ack <= 1'b0;
         // every received byte lands here; consumers clear it (or keep a same-cycle arrival)
         if (rx_vld) begin
            pend_vld <= 1'b1;
            pend_cmd <= rx_data;
         end
         case (state)
            BAT_WAIT:
               if (pend_vld && pend_cmd == 8'hFF) begin
                  start_ack(8'hFF);
                  pend_vld <= rx_vld;
                  cnt      <= '0;
               end else if (cnt == 32'(BAT_DELAY - 1)) begin
                  state   <= SEND_BAT;
                  tx_en   <= 1'b1;
                  tx_data <= 8'hAA;
                  cnt     <= '0;
               end else cnt <= cnt + 32'd1;
            SEND_BAT:
               if (tx_done) begin
                  state   <= SEND_ID;
                  tx_en   <= 1'b1;
                  tx_data <= 8'h00;
               end
            SEND_ID:   if (tx_done) state <= IDLE;
            SEND_RESP: if (tx_done) state <= IDLE;
            IDLE:
               if (pend_vld) begin
                  start_ack(pend_cmd);
                  pend_vld <= rx_vld;
               end else if (rx_vld) begin
                  start_ack(rx_data);
                  pend_vld <= 1'b0;
               end else if (pkt_req) begin
                  pkt_ack <= 1'b1;
                  if (stream_en) begin
                     state   <= SEND_PKT;
                     tx_en   <= 1'b1;
                     tx_data <= pkt_data[7:0];
                     pkt_hi  <= pkt_data[23:8];
                     idx     <= '0;
                  end
               end
            SEND_ACK:
               if (tx_done) begin
                  state <= (cur_cmd == 8'hFF) ? BAT_WAIT : (cur_cmd == 8'hF2) ? SEND_RESP : IDLE;
                  stream_en <= (cur_cmd == 8'hF4) ? 1'b1 : (cur_cmd == 8'hF5 || cur_cmd == 8'hFF) ? 1'b0 : stream_en;
                  cnt <= '0;
                  if (cur_cmd == 8'hF2) begin
                     tx_en   <= 1'b1;
                     tx_data <= 8'h00;
                  end
               end
            SEND_PKT:
               if (tx_done) begin
                  if (pend_vld) begin
                     start_ack(pend_cmd);
                     pend_vld <= rx_vld;
                  end else if (idx == 2'd2) state <= IDLE;
                  else begin
                     idx     <= idx + 2'd1;
                     tx_en   <= 1'b1;
                     tx_data <= (idx == 2'd0) ? pkt_hi[7:0] : pkt_hi[15:8];
                  end
               end
            default: state <= BAT_WAIT;
         endcase
      end
   end
endmodule

// File: tb/tb_ps2_mouse_responder.sv
// tb_ps2_mouse_responder: directed scenario bench with a transmitter model that
// logs every tx_en byte and answers with tx_done five cycles later.
module tb_ps2_mouse_responder;
   logic        clk_sys = 1'b0;
   logic        rst_n;
   logic        rx_vld;
   logic [7:0]  rx_data;
   logic        tx_en;
   logic [7:0]  tx_data;
   logic        tx_done;
   logic        pkt_req;
   logic [23:0] pkt_data;
   logic        pkt_ack;
   logic        stream_en;
   logic [2:0]  current_state;
   int total = 0;
   int bad = 0;
   logic [7:0] sent[$];
`ifdef PS2_RESP_ERR_EN
   localparam logic [7:0] UNSUP_RESP = 8'hFE;
`else
   localparam logic [7:0] UNSUP_RESP = 8'hFA;
`endif

   ps2_mouse_responder #(.BAT_DELAY(16)) dut (
      .clk_sys(clk_sys), .rst_n(rst_n), .rx_vld(rx_vld), .rx_data(rx_data),
      .tx_en(tx_en), .tx_data(tx_data), .tx_done(tx_done), .pkt_req(pkt_req),
      .pkt_data(pkt_data), .pkt_ack(pkt_ack), .stream_en(stream_en),
      .current_state(current_state)
   );

   always #5 clk_sys = ~clk_sys;

   // transmitter model: tx_done lands on the 5th rising edge after the tx_en edge
   initial begin
      tx_done = 1'b0;
      forever begin
         @(negedge clk_sys);
         while (tx_en) begin
            sent.push_back(tx_data);
            for (int k = 0; k < 4; k++) begin
               @(negedge clk_sys);
               total++;
               if (tx_en || tx_data !== sent[$]) begin
                  bad++;
                  $display("FAIL tx_hold got en=%b data=%h want en=0 data=%h", tx_en, tx_data, sent[$]);
               end
            end
            tx_done = 1'b1;
            @(negedge clk_sys);
            tx_done = 1'b0;
         end
      end
   end

   function automatic logic [47:0] log6();
      logic [47:0] r = '0;
      foreach (sent[i]) if (i < 6) r[47 - 8*i -: 8] = sent[i];
      return r;
   endfunction

   task automatic send_cmd(input logic [7:0] b);
      @(negedge clk_sys);
      rx_vld  = 1'b1;
      rx_data = b;
      @(negedge clk_sys);
      rx_vld  = 1'b0;
   endtask

   task automatic wait_idle(input int n, input int lim);
      for (int i = 0; i < lim; i++) begin
         @(negedge clk_sys);
         if (current_state == 3'd3 && sent.size() >= n) break;
      end
   endtask

   task automatic wait_ack(output bit acked);
      acked = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_sys);
         if (pkt_ack) begin
            acked = 1'b1;
            break;
         end
      end
      pkt_req = 1'b0;
   endtask

   task automatic test_reset();
      int cyc;
      rst_n = 1'b0;
      repeat (3) @(negedge clk_sys);
      total++; if (current_state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", current_state); end
      total++; if (tx_en !== 1'b0) begin bad++; $display("FAIL rst_tx_en got=%b want=0", tx_en); end
      total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data got=%h want=00", tx_data); end
      total++; if (pkt_ack !== 1'b0) begin bad++; $display("FAIL rst_pkt_ack got=%b want=0", pkt_ack); end
      total++; if (stream_en !== 1'b0) begin bad++; $display("FAIL rst_stream_en got=%b want=0", stream_en); end
      sent.delete();
      rst_n = 1'b1;
      cyc = 0;
      while (cyc < 100) begin
         @(posedge clk_sys); #1;
         cyc++;
         if (tx_en) break;
      end
      total++; if (cyc != 16) begin bad++; $display("FAIL bat_delay got=%0d want=16", cyc); end
      total++; if (tx_data !== 8'hAA) begin bad++; $display("FAIL bat_byte got=%h want=aa", tx_data); end
      wait_idle(2, 100);
      total++; if (sent.size() != 2 || log6() !== 48'hAA00_0000_0000) begin bad++; $display("FAIL bat_seq got=%h n=%0d want=aa00", log6(), sent.size()); end
      total++; if (current_state !== 3'd3) begin bad++; $display("FAIL bat_idle got=%0d want=3", current_state); end
   endtask

   task automatic test_stream_on();
      sent.delete();
      send_cmd(8'hF4);
      wait_idle(1, 50);
      total++; if (sent.size() != 1 || log6() !== 48'hFA00_0000_0000) begin bad++; $display("FAIL f4_ack got=%h n=%0d want=fa", log6(), sent.size()); end
      total++; if (stream_en !== 1'b1) begin bad++; $display("FAIL f4_stream got=%b want=1", stream_en); end
   endtask

   task automatic test_packet();
      bit acked;
      sent.delete();
      @(negedge clk_sys);
      pkt_req  = 1'b1;
      pkt_data = 24'h123456;
      wait_ack(acked);
      total++; if (!acked) begin bad++; $display("FAIL pkt_ack got=0 want=1"); end
      wait_idle(3, 100);
      total++; if (sent.size() != 3 || log6() !== 48'h5634_1200_0000) begin bad++; $display("FAIL pkt_bytes got=%h n=%0d want=563412", log6(), sent.size()); end
   endtask

   task automatic test_get_id();
      sent.delete();
      send_cmd(8'hF2);
      wait_idle(2, 100);
      total++; if (sent.size() != 2 || log6() !== 48'hFA00_0000_0000) begin bad++; $display("FAIL f2_seq got=%h n=%0d want=fa00", log6(), sent.size()); end
      total++; if (stream_en !== 1'b1) begin bad++; $display("FAIL f2_stream got=%b want=1", stream_en); end
   endtask

   task automatic test_abort();
      bit acked;
      sent.delete();
      @(negedge clk_sys);
      pkt_req  = 1'b1;
      pkt_data = 24'hABCDEF;
      wait_ack(acked);
      send_cmd(8'hF5);
      wait_idle(2, 100);
      repeat (20) @(negedge clk_sys);
      total++; if (sent.size() != 2 || log6() !== 48'hEFFA_0000_0000) begin bad++; $display("FAIL abort_seq got=%h n=%0d want=effa", log6(), sent.size()); end
      total++; if (stream_en !== 1'b0) begin bad++; $display("FAIL abort_stream got=%b want=0", stream_en); end
   endtask

   task automatic test_stream_off_pkt();
      bit acked;
      sent.delete();
      @(negedge clk_sys);
      pkt_req  = 1'b1;
      pkt_data = 24'h777777;
      wait_ack(acked);
      total++; if (!acked) begin bad++; $display("FAIL off_pkt_ack got=0 want=1"); end
      repeat (20) @(negedge clk_sys);
      total++; if (sent.size() != 0) begin bad++; $display("FAIL off_pkt_sent got=%0d want=0", sent.size()); end
      total++; if (current_state !== 3'd3) begin bad++; $display("FAIL off_pkt_state got=%0d want=3", current_state); end
   endtask

   task automatic test_unsupported();
      sent.delete();
      send_cmd(8'hEE);
      wait_idle(1, 50);
      total++; if (sent.size() != 1 || sent[0] !== UNSUP_RESP) begin bad++; $display("FAIL ee_resp got=%h n=%0d want=%h", log6(), sent.size(), UNSUP_RESP); end
      total++; if (current_state !== 3'd3) begin bad++; $display("FAIL ee_state got=%0d want=3", current_state); end
      total++; if (stream_en !== 1'b0) begin bad++; $display("FAIL ee_stream got=%b want=0", stream_en); end
   endtask

   task automatic test_same_cycle();
      bit acked;
      send_cmd(8'hF4);
      wait_idle(1, 50);
      sent.delete();
      @(negedge clk_sys);
      rx_vld   = 1'b1;
      rx_data  = 8'hF4;
      pkt_req  = 1'b1;
      pkt_data = 24'h010203;
      @(negedge clk_sys);
      rx_vld = 1'b0;
      total++; if (pkt_ack !== 1'b0 || current_state !== 3'd4) begin bad++; $display("FAIL same_cmd_first got ack=%b st=%0d want ack=0 st=4", pkt_ack, current_state); end
      acked = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk_sys);
         if (pkt_ack) begin
            acked = 1'b1;
            break;
         end
      end
      pkt_req = 1'b0;
      total++; if (!acked || current_state !== 3'd6) begin bad++; $display("FAIL same_pkt_ack got ack=%b st=%0d want ack=1 st=6", acked, current_state); end
      wait_idle(4, 100);
      total++; if (sent.size() != 4 || log6() !== 48'hFA03_0201_0000) begin bad++; $display("FAIL same_seq got=%h n=%0d want=fa030201", log6(), sent.size()); end
   endtask

   task automatic test_pending();
      sent.delete();
      send_cmd(8'hF2);
      repeat (2) @(negedge clk_sys);
      send_cmd(8'hF5);
      wait_idle(3, 150);
      total++; if (sent.size() != 3 || log6() !== 48'hFA00_FA00_0000) begin bad++; $display("FAIL pend_seq got=%h n=%0d want=fa00fa", log6(), sent.size()); end
      total++; if (stream_en !== 1'b0) begin bad++; $display("FAIL pend_stream got=%b want=0", stream_en); end
   endtask

   task automatic test_reset_cmd();
      send_cmd(8'hF4);
      wait_idle(1, 50);
      sent.delete();
      send_cmd(8'hFF);
      total++; if (current_state !== 3'd4) begin bad++; $display("FAIL ff_ack_state got=%0d want=4", current_state); end
      wait_idle(3, 200);
      total++; if (sent.size() != 3 || log6() !== 48'hFAAA_0000_0000) begin bad++; $display("FAIL ff_seq got=%h n=%0d want=faaa00", log6(), sent.size()); end
      total++; if (stream_en !== 1'b0) begin bad++; $display("FAIL ff_stream got=%b want=0", stream_en); end
   endtask

   task automatic test_pending_ff_bat();
      int cyc;
      rst_n = 1'b0;
      repeat (2) @(negedge clk_sys);
      rst_n = 1'b1;
      repeat (5) @(negedge clk_sys);
      sent.delete();
      send_cmd(8'hFF);
      @(negedge clk_sys);
      total++; if (current_state !== 3'd4) begin bad++; $display("FAIL batff_ack got=%0d want=4", current_state); end
      for (int i = 0; i < 20; i++) begin
         @(posedge clk_sys); #1;
         if (current_state == 3'd0) break;
      end
      cyc = 0;
      while (cyc < 100) begin
         @(posedge clk_sys); #1;
         cyc++;
         if (tx_en) break;
      end
      total++; if (cyc != 16) begin bad++; $display("FAIL batff_restart got=%0d want=16", cyc); end
      wait_idle(3, 100);
      total++; if (sent.size() != 3 || log6() !== 48'hFAAA_0000_0000) begin bad++; $display("FAIL batff_seq got=%h n=%0d want=faaa00", log6(), sent.size()); end
   endtask

   initial begin
      rst_n    = 1'b0;
      rx_vld   = 1'b0;
      rx_data  = 8'h00;
      pkt_req  = 1'b0;
      pkt_data = 24'h0;
      test_reset();
      test_stream_on();
      test_packet();
      test_get_id();
      test_abort();
      test_stream_off_pkt();
      test_unsupported();
      test_same_cycle();
      test_pending();
      test_reset_cmd();
      test_pending_ff_bat();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
